rv_multicycle_ctrl: RTL and testbench

- Control FSM that sequences the RV32I multi-cycle datapath: instruction fetch, decode, execute, memory access and register writeback.
- Consumes opcode/funct3/funct7 from the instruction field parser on the IR output.
- Drives the datapath strobes and mux selects for IR, PC, register file, ALU and the unified memory port.
- One instruction is in flight at a time.

---
 rtl/rv_ctrl_pkg.sv | 44 ++++
 rtl/rv_alu_decode.sv | 33 +++
 rtl/rv_multicycle_ctrl.sv | 113 +++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared encodings for the RV32I multi-cycle control FSM
package rv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_REL    = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;
  function automatic logic is_supported(input logic [6:0] op);
    return op == OP_R || op == OP_IMM || op == OP_LOAD || op == OP_STORE ||
           op == OP_BRANCH || op == OP_JAL || op == OP_JALR || op == OP_LUI ||
           op == OP_AUIPC;
  endfunction
endpackage

// File: rtl/rv_alu_decode.sv
// rv_alu_decode: maps opcode/funct3/funct7 onto the ALU operation code
module rv_alu_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl
);
  logic is_r;
  logic is_i;
  logic alt;
  logic [3:0] f3_op;
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
  assign is_r = opcode == OP_R;
  assign is_i = opcode == OP_IMM;
  assign alt  = funct7[5];
  always_comb begin
    f3_op = ALU_ADD;
    case (funct3)
      3'b000:  f3_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end
  assign alu_ctrl = (is_r || is_i) ? f3_op : (opcode == OP_BRANCH) ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: fetch/decode/exec/mem/wb control FSM for the RV32I multi-cycle datapath
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic [2:0] state,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_instr,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);
  logic [2:0] state_q, state_d;
  logic illegal_q, illegal_d;
  logic [3:0] dec_alu;
  logic is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic sel_a, sel_b;
  rv_alu_decode u_alu_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_alu)
  );
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_jal    = opcode == OP_JAL;
  assign is_jalr   = opcode == OP_JALR;
  assign is_lui    = opcode == OP_LUI;
  assign sel_a     = opcode == OP_AUIPC || is_jal;
  assign sel_b     = !(opcode == OP_R || is_branch);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = is_supported(opcode) ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = is_branch ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
      S_MEM:    state_d = !mem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end
  assign illegal_d = illegal_q || state_d == S_TRAP;
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_instr = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_ctrl     = ALU_ADD;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req      = 1'b1;
          mem_is_instr = 1'b1;
          ir_write     = mem_ready;
          pc_write     = mem_ready;
        end
        S_EXEC: begin
          alu_src_a = sel_a;
          alu_src_b = sel_b;
          alu_ctrl  = dec_alu;
          pc_write  = (is_branch && branch_taken) || is_jal || is_jalr;
          pc_src    = is_jalr ? PC_JALR : (is_branch || is_jal) ? PC_REL : PC_PLUS4;
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_we    = is_store;
          alu_src_b = 1'b1;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = is_load ? WB_MEM : (is_jal || is_jalr) ? WB_PC4 : is_lui ? WB_IMM : WB_ALU;
          alu_src_a = sel_a;
          alu_src_b = sel_b;
          alu_ctrl  = dec_alu;
        end
        default: ;
      endcase
    end
  end
  assign state   = state_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed checks of the multi-cycle control FSM
module tb_rv_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic mem_ready, branch_taken;
  logic [2:0] state;
  logic mem_req, mem_we, mem_is_instr, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, wb_sel;
  logic alu_src_a, alu_src_b, illegal;
  logic [3:0] alu_ctrl;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0;
  rv_multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .state        (state),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_is_instr (mem_is_instr),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .illegal      (illegal)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    branch_taken = 1'b0;
    set_op(7'b0110011, 3'd0, 7'd0);
    step;
    step;
    check("rst_state", state, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_ir_write", ir_write, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b0;
    #1;
    t0 = cyc;
    check("add_fetch_state", state, 0);
    check("add_fetch_req", {mem_req, mem_is_instr, ir_write, pc_write}, 4'b1111);
    check("add_fetch_pcsrc", pc_src, 0);
    step;
    check("add_decode_state", state, 1);
    check("add_decode_req", mem_req, 0);
    step;
    check("add_exec_state", state, 2);
    check("add_exec_alu", alu_ctrl, 0);
    check("add_exec_srcs", {alu_src_a, alu_src_b}, 2'b00);
    check("add_exec_rw", reg_write, 0);
    step;
    check("add_wb_state", state, 4);
    check("add_wb_rw_sel", {reg_write, wb_sel}, 3'b100);
    step;
    check("add_back_fetch", state, 0);
    check("add_no_rw", reg_write, 0);
    check("add_latency", cyc - t0, 4);
    set_op(7'b0110011, 3'd0, 7'b0100000);
    step;
    step;
    check("sub_exec_alu", alu_ctrl, 1);
    step;
    check("sub_wb", {state, reg_write, wb_sel}, {3'd4, 1'b1, 2'd0});
    step;
    set_op(7'b0010011, 3'd0, 7'b0100000);
    step;
    step;
    check("addi_alu", alu_ctrl, 0);
    check("addi_srcb", {alu_src_a, alu_src_b}, 2'b01);
    step;
    step;
    set_op(7'b0010011, 3'b101, 7'b0100000);
    step;
    step;
    check("srai_alu", alu_ctrl, 7);
    step;
    step;
    set_op(7'b0000011, 3'd2, 7'd0);
    t0 = cyc;
    step;
    step;
    check("lw_exec", {state, alu_src_b, alu_ctrl}, {3'd2, 1'b1, 4'd0});
    mem_ready = 1'b0;
    step;
    check("lw_mem1", {state, mem_req, mem_we, mem_is_instr}, {3'd3, 3'b100});
    step;
    check("lw_mem2", {state, mem_req, mem_we}, {3'd3, 2'b10});
    step;
    check("lw_mem3", {state, mem_req, mem_we}, {3'd3, 2'b10});
    mem_ready = 1'b1;
    step;
    check("lw_wb", {state, reg_write, wb_sel}, {3'd4, 1'b1, 2'd1});
    step;
    check("lw_latency", cyc - t0, 7);
    check("lw_fetch", state, 0);
    set_op(7'b0100011, 3'd2, 7'd0);
    t0 = cyc;
    step;
    step;
    step;
    check("sw_mem", {state, mem_req, mem_we, reg_write}, {3'd3, 3'b110});
    step;
    check("sw_fetch", {state, reg_write}, {3'd0, 1'b0});
    check("sw_latency", cyc - t0, 4);
    set_op(7'b1100011, 3'd0, 7'd0);
    branch_taken = 1'b1;
    t0 = cyc;
    step;
    step;
    check("beq_t_exec", {state, pc_write, pc_src, alu_ctrl}, {3'd2, 1'b1, 2'd1, 4'd1});
    step;
    check("beq_t_fetch", state, 0);
    check("beq_t_latency", cyc - t0, 3);
    branch_taken = 1'b0;
    t0 = cyc;
    step;
    step;
    check("beq_n_pcw", pc_write, 0);
    step;
    check("beq_n_latency", {state, 8'(cyc - t0)}, {3'd0, 8'd3});
    set_op(7'b1101111, 3'd0, 7'd0);
    step;
    step;
    check("jal_exec", {pc_write, pc_src}, 3'b101);
    step;
    check("jal_wb", {reg_write, wb_sel}, 3'b110);
    step;
    set_op(7'b1100111, 3'd0, 7'd0);
    step;
    step;
    check("jalr_exec", {pc_write, pc_src}, 3'b110);
    step;
    check("jalr_wb", wb_sel, 2);
    step;
    set_op(7'b0110111, 3'd0, 7'd0);
    step;
    step;
    step;
    check("lui_wb", {state, wb_sel}, {3'd4, 2'd3});
    step;
    set_op(7'b0100011, 3'd0, 7'd0);
    step;
    step;
    step;
    check("rstmem_state", state, 3);
    rst = 1'b1;
    #1;
    check("rstmem_strobes", {mem_we, mem_req}, 2'b00);
    step;
    rst = 1'b0;
    #1;
    check("rstmem_after", {state, mem_req}, {3'd0, 1'b1});
    set_op(7'b1111111, 3'd0, 7'd0);
    step;
    step;
    check("trap_enter", {state, illegal}, {3'd5, 1'b1});
    for (int i = 0; i < 10; i++) begin
      step;
      check("trap_hold", {state, illegal, mem_req, pc_write, reg_write}, {3'd5, 4'b1000});
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    check("trap_cleared", {state, illegal}, {3'd0, 1'b0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
